// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the fetch/request units, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; the master modport is the requester/RAM side.
interface mem_access_arbiter_if #(
  parameter int unsigned WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic [1:0]        ramstate;
  logic [WORD_W-1:0] ramload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic              iwait;
  logic              dwait;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload, err
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Single-port RAM arbiter: data-first priority with alternation to keep fetch from starving.
// Optional grant timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_access_arbiter #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input logic                  CLK,
  input logic                  RST,
  mem_access_arbiter_if.slave  bus
);

  localparam logic [1:0]        RS_ACCESS = 2'd2;
  localparam logic [1:0]        RS_ERROR  = 2'd3;
  localparam logic [WORD_W-1:0] ZERO      = '0;

  if (TIMEOUT_CYCLES == 0 || $clog2(TIMEOUT_CYCLES + 1) > int'(CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } state_t;

  state_t state, state_n;
  logic   last_d, last_d_n;
  logic   dreq, done, rerr, tmo, abort;

  // State and fairness bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_n;
      last_d <= last_d_n;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  // Cycles spent in the current grant; cleared whenever the FSM passes through IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (state != IDLE && state_n != IDLE) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign tmo = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // Next state, RAM drive and per-port handshake
  always_comb begin
    dreq  = bus.dREN | bus.dWEN;
    done  = (bus.ramstate == RS_ACCESS) || (bus.ramstate == RS_ERROR);
    rerr  = (bus.ramstate == RS_ERROR);
    abort = rerr || (!done && tmo);

    state_n      = state;
    last_d_n     = last_d;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ZERO;
    bus.ramstore = ZERO;
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    bus.iload    = ZERO;
    bus.dload    = ZERO;
    bus.err      = 1'b0;

    case (state)
      IDLE: begin
        if (dreq && bus.iREN) begin
          state_n = last_d ? INSTR : DATA;
        end else if (dreq) begin
          state_n = DATA;
        end else if (bus.iREN) begin
          state_n = INSTR;
        end
      end
      DATA: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (!dreq) begin
          state_n = IDLE;
        end else if (done || tmo) begin
          bus.dwait = 1'b0;
          bus.dload = abort ? ZERO : bus.ramload;
          bus.err   = abort;
          state_n   = IDLE;
          last_d_n  = 1'b1;
        end
      end
      INSTR: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
        if (!bus.iREN) begin
          state_n = IDLE;
        end else if (done || tmo) begin
          bus.iwait = 1'b0;
          bus.iload = abort ? ZERO : bus.ramload;
          bus.err   = abort;
          state_n   = IDLE;
          last_d_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Reset silences the RAM port in the same cycle it is asserted
    if (RST) begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = ZERO;
      bus.ramstore = ZERO;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.iload    = ZERO;
      bus.dload    = ZERO;
      bus.err      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter; timeout scenario follows MEM_ARB_TIMEOUT_EN.
module tb_mem_access_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO    = 8;
  localparam bit          TMO_EN = 1'b1;
`else
  localparam int unsigned TMO    = 64;
  localparam bit          TMO_EN = 1'b0;
`endif

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  typedef struct {
    bit          is_d;
    logic [31:0] load;
    logic        err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  mem_access_arbiter_if #(.WORD_W(32)) bus ();

  mem_access_arbiter #(
    .WORD_W(32), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    cyc();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.ramstate = FREE; bus.ramload = '0;
  endtask

  task automatic test_reset();
    RST = 1; bus.iREN = 1; bus.dREN = 1; bus.dWEN = 0;
    bus.iaddr = 32'h10; bus.daddr = 32'h20; bus.dstore = '0;
    bus.ramstate = ACCESS; bus.ramload = 32'h1234;
    cyc(); cyc(); #1;
    vectors++; if (bus.ramREN !== 1'b0) begin miscompares++; $display("FAIL reset_ramREN: got %b want 0", bus.ramREN); end
    vectors++; if (bus.ramWEN !== 1'b0) begin miscompares++; $display("FAIL reset_ramWEN: got %b want 0", bus.ramWEN); end
    vectors++; if (bus.iwait !== 1'b1) begin miscompares++; $display("FAIL reset_iwait: got %b want 1", bus.iwait); end
    vectors++; if (bus.dwait !== 1'b1) begin miscompares++; $display("FAIL reset_dwait: got %b want 1", bus.dwait); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.err); end
    cyc();
    RST = 0; bus.iREN = 0; bus.dREN = 0; bus.ramstate = FREE;
    #1;
    vectors++; if ({bus.ramREN, bus.iwait, bus.dwait} !== 3'b000) begin miscompares++; $display("FAIL reset_idle: got %b want 000", {bus.ramREN, bus.iwait, bus.dwait}); end
  endtask

  task automatic test_fetch();
    exp_t e;
    cyc();
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = FREE;
    sb.push_back('{is_d: 1'b0, load: 32'h8C010004, err: 1'b0});
    #1;
    vectors++; if ({bus.iwait, bus.ramREN} !== 2'b10) begin miscompares++; $display("FAIL fetch_req_cycle: got %b want 10", {bus.iwait, bus.ramREN}); end
    cyc();
    bus.ramstate = ACCESS; bus.ramload = 32'h8C010004;
    #1;
    vectors++; if (bus.ramaddr !== 32'h40 || bus.ramREN !== 1'b1) begin miscompares++; $display("FAIL fetch_ramaddr: got %h/%b want 00000040/1", bus.ramaddr, bus.ramREN); end
    vectors++;
    if (bus.iwait !== 1'b0) begin
      miscompares++; $display("FAIL fetch_latency: iwait got %b want 0", bus.iwait);
    end else begin
      e = sb.pop_front();
      vectors++; if (bus.iload !== e.load || bus.err !== e.err) begin miscompares++; $display("FAIL fetch_iload: got %h/%b want %h/%b", bus.iload, bus.err, e.load, e.err); end
    end
    cyc();
    bus.iREN = 0; bus.ramstate = FREE;
    #1;
    vectors++; if (bus.ramREN !== 1'b0) begin miscompares++; $display("FAIL fetch_release: ramREN got %b want 0", bus.ramREN); end
    sb.delete();
  endtask

  task automatic test_contention();
    exp_t e;
    cyc();
    bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
    bus.iREN = 1; bus.iaddr = 32'h80; bus.ramstate = FREE;
    sb.push_back('{is_d: 1'b1, load: 32'h0, err: 1'b0});
    sb.push_back('{is_d: 1'b0, load: 32'hA5A5_0080, err: 1'b0});
    cyc();
    bus.ramstate = ACCESS; bus.ramload = 32'hA5A5_0080;
    #1;
    vectors++; if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramaddr !== 32'h200 || bus.ramstore !== 32'h12345678) begin miscompares++; $display("FAIL cont_data_first: got %b %h %h want 10 00000200 12345678", {bus.ramWEN, bus.ramREN}, bus.ramaddr, bus.ramstore); end
    e = sb.pop_front();
    vectors++; if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1 || !e.is_d) begin miscompares++; $display("FAIL cont_data_done: dwait/iwait got %b%b want 01", bus.dwait, bus.iwait); end
    cyc();
    bus.dWEN = 0;
    #1;
    vectors++; if ({bus.ramWEN, bus.ramREN, bus.iwait} !== 3'b001) begin miscompares++; $display("FAIL cont_gap_idle: got %b want 001", {bus.ramWEN, bus.ramREN, bus.iwait}); end
    cyc(); #1;
    e = sb.pop_front();
    vectors++; if (bus.ramaddr !== 32'h80 || bus.iwait !== 1'b0 || bus.iload !== e.load) begin miscompares++; $display("FAIL cont_instr: got %h/%b/%h want 00000080/0/%h", bus.ramaddr, bus.iwait, bus.iload, e.load); end
    idle_bus();
  endtask

  task automatic test_starvation();
    exp_t e;
    int   grants;
    cyc();
    bus.dREN = 1; bus.daddr = 32'h300; bus.iREN = 1; bus.iaddr = 32'h400;
    bus.ramstate = ACCESS;
    for (int g = 0; g < 6; g++) begin
      if (g % 2 == 0) sb.push_back('{is_d: 1'b1, load: 32'h1300, err: 1'b0});
      else            sb.push_back('{is_d: 1'b0, load: 32'h1400, err: 1'b0});
    end
    grants = 0;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      cyc();
      bus.ramload = bus.ramaddr + 32'h1000;
      #1;
      if (bus.dwait === 1'b0) begin
        e = sb.pop_front(); grants++;
        vectors++; if (!e.is_d || bus.dload !== e.load) begin miscompares++; $display("FAIL starve_grant%0d: data done load %h want port %s load %h", grants, bus.dload, e.is_d ? "d" : "i", e.load); end
      end
      if (bus.iwait === 1'b0) begin
        e = sb.pop_front(); grants++;
        vectors++; if (e.is_d || bus.iload !== e.load) begin miscompares++; $display("FAIL starve_grant%0d: instr done load %h want port %s load %h", grants, bus.iload, e.is_d ? "d" : "i", e.load); end
      end
    end
    vectors++; if (sb.size() != 0 || grants != 6) begin miscompares++; $display("FAIL starve_count: got %0d grants want 6", grants); end
    sb.delete();
    idle_bus();
  endtask

  task automatic test_both_rw();
    exp_t e;
    cyc();
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; bus.ramstate = BUSY;
    sb.push_back('{is_d: 1'b1, load: 32'h0, err: 1'b0});
    cyc(); #1;
    vectors++; if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramstore !== 32'hDEADBEEF || bus.ramaddr !== 32'h100) begin miscompares++; $display("FAIL both_write_wins: got %b %h %h want 10 00000100 deadbeef", {bus.ramWEN, bus.ramREN}, bus.ramaddr, bus.ramstore); end
    vectors++; if (bus.dwait !== 1'b1) begin miscompares++; $display("FAIL both_busy_hold: dwait got %b want 1", bus.dwait); end
    cyc();
    bus.daddr = 32'h104; bus.ramstate = ACCESS;
    #1;
    e = sb.pop_front();
    vectors++; if (bus.ramaddr !== 32'h104 || bus.dwait !== 1'b0 || bus.err !== e.err) begin miscompares++; $display("FAIL both_follow_done: got %h/%b/%b want 00000104/0/%b", bus.ramaddr, bus.dwait, bus.err, e.err); end
    idle_bus();
  endtask

  task automatic test_error();
    exp_t e;
    cyc();
    bus.dREN = 1; bus.daddr = 32'h500; bus.ramstate = FREE;
    sb.push_back('{is_d: 1'b1, load: 32'h0, err: 1'b1});
    cyc();
    bus.ramstate = ERROR; bus.ramload = 32'hFFFFFFFF;
    #1;
    e = sb.pop_front();
    vectors++; if (bus.dwait !== 1'b0 || bus.dload !== e.load || bus.err !== e.err) begin miscompares++; $display("FAIL error_done: got %b/%h/%b want 0/%h/%b", bus.dwait, bus.dload, bus.err, e.load, e.err); end
    cyc();
    bus.dREN = 0; bus.ramstate = FREE;
    #1;
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL error_pulse: err got %b want 0", bus.err); end
  endtask

  task automatic test_drop();
    cyc();
    bus.iREN = 1; bus.iaddr = 32'h600; bus.ramstate = BUSY;
    cyc(); #1;
    vectors++; if ({bus.ramREN, bus.iwait} !== 2'b11) begin miscompares++; $display("FAIL drop_grant: got %b want 11", {bus.ramREN, bus.iwait}); end
    cyc();
    bus.iREN = 0;
    #1;
    vectors++; if ({bus.ramREN, bus.iwait, bus.err} !== 3'b100) begin miscompares++; $display("FAIL drop_cycle: got %b want 100", {bus.ramREN, bus.iwait, bus.err}); end
    cyc(); #1;
    vectors++; if (bus.ramREN !== 1'b0) begin miscompares++; $display("FAIL drop_release: ramREN got %b want 0", bus.ramREN); end
  endtask

  task automatic test_hold_timeout();
    int  n;
    bit  exp_done;
    exp_t e;
    cyc();
    bus.dREN = 1; bus.daddr = 32'h700; bus.ramstate = BUSY;
    sb.push_back('{is_d: 1'b1, load: 32'h0, err: 1'b1});
    n = TMO_EN ? int'(TMO) : 20;
    for (int k = 1; k <= n; k++) begin
      cyc(); #1;
      exp_done = TMO_EN && (k == int'(TMO));
      vectors++; if (bus.dwait !== !exp_done || bus.err !== exp_done || bus.ramREN !== 1'b1) begin miscompares++; $display("FAIL hold_cycle%0d: dwait/err/ramREN got %b%b%b want %b%b1", k, bus.dwait, bus.err, bus.ramREN, !exp_done, exp_done); end
      if (exp_done) begin
        e = sb.pop_front();
        vectors++; if (bus.dload !== e.load) begin miscompares++; $display("FAIL timeout_load: got %h want %h", bus.dload, e.load); end
      end
    end
`ifndef MEM_ARB_TIMEOUT_EN
    cyc();
    bus.ramstate = ACCESS; bus.ramload = 32'h77;
    #1;
    void'(sb.pop_front());
    vectors++; if (bus.dwait !== 1'b0 || bus.dload !== 32'h77 || bus.err !== 1'b0) begin miscompares++; $display("FAIL hold_late_done: got %b/%h/%b want 0/00000077/0", bus.dwait, bus.dload, bus.err); end
`endif
    sb.delete();
    idle_bus();
  endtask

  task automatic test_reset_mid();
    cyc();
    bus.dWEN = 1; bus.daddr = 32'h800; bus.dstore = 32'h1; bus.ramstate = BUSY;
    cyc(); #1;
    vectors++; if (bus.ramWEN !== 1'b1) begin miscompares++; $display("FAIL rstmid_grant: ramWEN got %b want 1", bus.ramWEN); end
    RST = 1;
    #1;
    vectors++; if ({bus.ramWEN, bus.dwait} !== 2'b01) begin miscompares++; $display("FAIL rstmid_comb: got %b want 01", {bus.ramWEN, bus.dwait}); end
    cyc();
    RST = 0;
    #1;
    vectors++; if ({bus.ramWEN, bus.dwait} !== 2'b01) begin miscompares++; $display("FAIL rstmid_idle: got %b want 01", {bus.ramWEN, bus.dwait}); end
    cyc(); #1;
    vectors++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h800) begin miscompares++; $display("FAIL rstmid_regrant: got %b/%h want 1/00000800", bus.ramWEN, bus.ramaddr); end
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_starvation();
    test_both_rw();
    test_error();
    test_drop();
    test_hold_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
